// File: rtl/scottcpu_pkg.sv
// Shared constants for the scottcpu ALU: opcodes, FSM state encoding and status-flag indices.
package scottcpu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SHL = 4'd1;
  localparam logic [3:0] OP_SHR = 4'd2;
  localparam logic [3:0] OP_NOT = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SUB = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit positions reserved for the status register that will latch Cfout/Zf/Ef/Af.
  localparam int unsigned FLAG_C     = 0;
  localparam int unsigned FLAG_Z     = 1;
  localparam int unsigned FLAG_E     = 2;
  localparam int unsigned FLAG_A     = 3;
  localparam int unsigned FLAG_COUNT = 4;

endpackage

// File: rtl/scottcpu_alu_comb.sv
// Combinational result and carry for every single-cycle ALU opcode; anything else yields 0/0.
module scottcpu_alu_comb
  import scottcpu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  input  logic             cfin_i,
  output logic [WIDTH-1:0] res_o,
  output logic             cf_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum   = '0;
    res_o = '0;
    cf_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        sum   = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cfin_i};
        res_o = sum[WIDTH-1:0];
        cf_o  = sum[WIDTH];
      end
      // Subtract as A + ~B + !Cfin; a clear carry-out means a borrow occurred.
      OP_SUB: begin
        sum   = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, ~cfin_i};
        res_o = sum[WIDTH-1:0];
        cf_o  = ~sum[WIDTH];
      end
      OP_SHL: begin
        res_o = {a_i[WIDTH-2:0], cfin_i};
        cf_o  = a_i[WIDTH-1];
      end
      OP_SHR: begin
        res_o = {cfin_i, a_i[WIDTH-1:1]};
        cf_o  = a_i[0];
      end
      OP_ROL: begin
        res_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
        cf_o  = a_i[WIDTH-1];
      end
      OP_ROR: begin
        res_o = {a_i[0], a_i[WIDTH-1:1]};
        cf_o  = a_i[0];
      end
      OP_NOT: res_o = ~a_i;
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/scottcpu_alu_seq.sv
// Registered, handshaked scottcpu ALU with optional iterative multiplier.
// Define SCOTTCPU_ALU_MUL_EN to build MUL and the BUSY state; otherwise opcode 10 is illegal.
module scottcpu_alu_seq
  import scottcpu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       OP,
  input  logic             Cfin,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_HI,
  output logic             Cfout,
  output logic             Zf,
  output logic             Ef,
  output logic             Af
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
  logic             cf_q, cf_d, zf_q, zf_d, ef_q, ef_d, af_q, af_d;
  logic             accept;
  logic [WIDTH-1:0] comb_res;
  logic             comb_cf;

`ifdef SCOTTCPU_ALU_MUL_EN
  localparam int unsigned MUL_CYCLES_LOG2 = $clog2(WIDTH + 1);
  localparam logic [MUL_CYCLES_LOG2-1:0] MUL_LAST = MUL_CYCLES_LOG2'(WIDTH - 1);

  logic [WIDTH-1:0]           mcand_q, mcand_d, prod_hi_q, prod_hi_d, prod_lo_q, prod_lo_d;
  logic [MUL_CYCLES_LOG2-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]             mul_sum;
`endif

  scottcpu_alu_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a_i   (A),
    .b_i   (B),
    .op_i  (OP),
    .cfin_i(Cfin),
    .res_o (comb_res),
    .cf_o  (comb_cf)
  );

  // A held result may be released and replaced by a new op on the same edge.
  assign IN_READY  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & OUT_READY);
  assign accept    = IN_VALID & IN_READY;
  assign OUT_VALID = (state_q == ST_DONE);

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    ef_d     = ef_q;
    af_d     = af_q;
`ifdef SCOTTCPU_ALU_MUL_EN
    mcand_d   = mcand_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    cnt_d     = cnt_q;
    mul_sum   = '0;
`endif

    case (state_q)
      ST_DONE: if (OUT_READY) state_d = ST_IDLE;
`ifdef SCOTTCPU_ALU_MUL_EN
      // Shift-add: the multiplier drains out of prod_lo from the bottom while product bits
      // enter from the top, so {prod_hi, prod_lo} is the full product after WIDTH steps.
      ST_BUSY: begin
        mul_sum   = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, mcand_q} : '0);
        prod_hi_d = mul_sum[WIDTH:1];
        prod_lo_d = {mul_sum[0], prod_lo_q[WIDTH-1:1]};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == MUL_LAST) begin
          state_d  = ST_DONE;
          out_d    = prod_lo_d;
          out_hi_d = prod_hi_d;
          cf_d     = |prod_hi_d;
          zf_d     = ~|{prod_hi_d, prod_lo_d};
        end
      end
`endif
      default: ;
    endcase

    if (accept) begin
      ef_d     = (A == B);
      af_d     = (A > B);
      state_d  = ST_DONE;
      out_d    = comb_res;
      out_hi_d = '0;
      cf_d     = comb_cf;
      zf_d     = (comb_res == '0);
`ifdef SCOTTCPU_ALU_MUL_EN
      if (OP == OP_MUL) begin
        state_d   = ST_BUSY;
        mcand_d   = A;
        prod_lo_d = B;
        prod_hi_d = '0;
        cnt_d     = '0;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      out_hi_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      ef_q     <= 1'b0;
      af_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      ef_q     <= ef_d;
      af_q     <= af_d;
    end
  end

`ifdef SCOTTCPU_ALU_MUL_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      mcand_q   <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      cnt_q     <= '0;
    end else begin
      mcand_q   <= mcand_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      cnt_q     <= cnt_d;
    end
  end
`endif

  assign OUT    = out_q;
  assign OUT_HI = out_hi_q;
  assign Cfout  = cf_q;
  assign Zf     = zf_q;
  assign Ef     = ef_q;
  assign Af     = af_q;

endmodule

// File: tb/tb_scottcpu_alu_seq.sv
// Self-checking bench for scottcpu_alu_seq: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_scottcpu_alu_seq;

  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   OP;
  logic         Cfin;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] OUT;
  logic [W-1:0] OUT_HI;
  logic         Cfout;
  logic         Zf;
  logic         Ef;
  logic         Af;

  int n_tests = 0;
  int n_fail  = 0;

  scottcpu_alu_seq #(
    .WIDTH(W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A        (A),
    .B        (B),
    .OP       (OP),
    .Cfin     (Cfin),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT      (OUT),
    .OUT_HI   (OUT_HI),
    .Cfout    (Cfout),
    .Zf       (Zf),
    .Ef       (Ef),
    .Af       (Af)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         cf;
    logic         zf;
    logic         ef;
    logic         af;
    int           lat;
  } exp_t;

  // Result of one operation computed with plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ci);
    exp_t   e;
    longint ua, ub, uc, r, mask;
    ua    = longint'(a);
    ub    = longint'(b);
    uc    = longint'(ci);
    mask  = (longint'(1) << W) - 1;
    r     = 0;
    e.hi  = '0;
    e.cf  = 1'b0;
    e.lat = 1;
    case (op)
      4'd0: begin r = ua + ub + uc;                       e.cf = (r > mask);  end
      4'd1: begin r = (ua << 1) | uc;                     e.cf = a[W-1];      end
      4'd2: begin r = (ua >> 1) | (uc << (W - 1));        e.cf = a[0];        end
      4'd3: r = ~ua;
      4'd4: r = ua & ub;
      4'd5: r = ua | ub;
      4'd6: r = ua ^ ub;
      4'd7: begin r = ua - ub - uc;                       e.cf = (r < 0);     end
      4'd8: begin r = (ua << 1) | (ua >> (W - 1));        e.cf = a[W-1];      end
      4'd9: begin r = (ua >> 1) | ((ua & 1) << (W - 1)); e.cf = a[0];        end
`ifdef SCOTTCPU_ALU_MUL_EN
      4'd10: begin
        r     = ua * ub;
        e.hi  = W'(r >> W);
        e.cf  = (e.hi != 0);
        e.lat = W + 1;
      end
`endif
      default: r = 0;
    endcase
    e.out = W'(r & mask);
    e.zf  = (e.out == 0) && (e.hi == 0);
    e.ef  = (a == b);
    e.af  = (a > b);
    return e;
  endfunction

  // Model: at most one outstanding result, valid from its due cycle until taken.
  exp_t pend;
  bit   have_pend   = 1'b0;
  bit   model_on    = 1'b0;
  bit   expect_zero = 1'b0;
  int   cyc         = 0;
  int   pend_cyc    = 0;

  always @(negedge CLK) begin
    bit ev;
    bit er;
    ev = have_pend && (cyc >= pend_cyc);
    er = !have_pend || (ev && OUT_READY);
    if (model_on) begin
      check("in_ready", IN_READY, er);
      check("out_valid", OUT_VALID, ev);
      if (ev) begin
        check("out", OUT, pend.out);
        check("out_hi", OUT_HI, pend.hi);
        check("cfout", Cfout, pend.cf);
        check("zf", Zf, pend.zf);
        check("ef", Ef, pend.ef);
        check("af", Af, pend.af);
      end
      if (expect_zero) begin
        check("rst_outputs", {OUT, OUT_HI, Cfout, Zf, Ef, Af}, 0);
      end
    end
    if (RST) begin
      model_on    = 1'b1;
      have_pend   = 1'b0;
      expect_zero = 1'b1;
    end else if (model_on) begin
      expect_zero = 1'b0;
      if (ev && OUT_READY) have_pend = 1'b0;
      if (IN_VALID && er) begin
        pend      = model(OP, A, B, Cfin);
        have_pend = 1'b1;
        pend_cyc  = cyc + pend.lat;
      end
    end
    cyc++;
  end

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci);
    bit done;
    done     = 1'b0;
    IN_VALID = 1'b1;
    OP       = op;
    A        = a;
    B        = b;
    Cfin     = ci;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      done = (IN_READY === 1'b1);
      @(posedge CLK);
      #1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: op %0d not accepted within 50 cycles", op);
    end
    IN_VALID = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    A         = '0;
    B         = '0;
    OP        = '0;
    Cfin      = 1'b0;
    OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    @(negedge CLK);
    check("reset_in_ready", IN_READY, 1);
    check("reset_out_valid", OUT_VALID, 0);
    check("reset_out", {OUT, OUT_HI}, 0);
    check("reset_flags", {Cfout, Zf, Ef, Af}, 0);
    step();

    issue(4'd0, 8'd34, 8'd64, 1'b1);
    @(negedge CLK);
    check("add_valid", OUT_VALID, 1);
    check("add_out", OUT, 99);
    check("add_flags_czea", {Cfout, Zf, Ef, Af}, 4'b0000);
    step();

    issue(4'd7, 8'd5, 8'd7, 1'b0);
    @(negedge CLK);
    check("sub_out", OUT, 254);
    check("sub_flags_czea", {Cfout, Zf, Ef, Af}, 4'b1000);
    step();

    issue(4'd0, 8'd255, 8'd1, 1'b0);
    @(negedge CLK);
    check("wrap_out", OUT, 0);
    check("wrap_cf_zf", {Cfout, Zf}, 2'b11);
    step();

`ifdef SCOTTCPU_ALU_MUL_EN
    issue(4'd10, 8'd200, 8'd3, 1'b0);
    for (int i = 0; i < W; i++) begin
      @(negedge CLK);
      check("mul_busy_in_ready", IN_READY, 0);
      step();
    end
    @(negedge CLK);
    check("mul_valid", OUT_VALID, 1);
    check("mul_lo", OUT, 88);
    check("mul_hi", OUT_HI, 2);
    check("mul_cf", Cfout, 1);
    step();
`else
    issue(4'd10, 8'hA5, 8'h5A, 1'b1);
    @(negedge CLK);
    check("op10_valid", OUT_VALID, 1);
    check("op10_out", {OUT, OUT_HI}, 0);
    check("op10_cf_zf", {Cfout, Zf}, 2'b01);
    step();
`endif

    issue(4'd15, 8'h3C, 8'h3C, 1'b1);
    @(negedge CLK);
    check("op15_out", OUT, 0);
    check("op15_czea", {Cfout, Zf, Ef, Af}, 4'b0110);
    step();

    OUT_READY = 1'b0;
    issue(4'd8, 8'h81, 8'h10, 1'b0);
    IN_VALID = 1'b1;
    OP       = 4'd4;
    A        = 8'hF0;
    B        = 8'h3C;
    Cfin     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("hold_out", OUT, 8'h03);
      check("hold_cf_valid", {Cfout, OUT_VALID}, 2'b11);
      check("hold_in_ready", IN_READY, 0);
      step();
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("handoff_in_ready", IN_READY, 1);
    step();
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("handoff_out", OUT, 8'h30);
    check("handoff_ea", {OUT_VALID, Ef, Af}, 3'b101);
    step();

`ifdef SCOTTCPU_ALU_MUL_EN
    issue(4'd10, 8'd200, 8'd3, 1'b0);
`else
    OUT_READY = 1'b0;
    issue(4'd0, 8'hFF, 8'hFF, 1'b1);
`endif
    repeat (3) step();
    RST = 1'b1;
    step();
    RST       = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("rst2_in_ready", IN_READY, 1);
    check("rst2_out_valid", OUT_VALID, 0);
    check("rst2_outputs", {OUT, OUT_HI, Cfout, Zf, Ef, Af}, 0);
    step();
    issue(4'd4, 8'hF0, 8'h3C, 1'b0);
    @(negedge CLK);
    check("post_rst_and", OUT, 8'h30);
    step();

    for (int i = 0; i < 400; i++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OP        = 4'($urandom_range(0, 15));
      A         = W'($urandom);
      B         = ($urandom_range(0, 7) == 0) ? A : W'($urandom);
      Cfin      = 1'($urandom);
      OUT_READY = ($urandom_range(0, 3) != 0);
      RST       = ($urandom_range(0, 99) == 0);
      step();
    end
    RST       = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    repeat (W + 4) step();
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
